data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
- Sequences all accesses to the data memory and shares its single access port between two requesters: the BIP core and the debug/UART interface.
- Each requester issues a req/ack transaction. The arbiter selects one winner, drives the memory's WrRd/address/data lines for one cycle, captures the read word the memory registers on the falling edge, and returns it with a one-cycle ack.
- The memory's interface-side port is tied idle (2'b00) by the top level. All memory traffic goes through this block.

Parameters:
- ADDR_LENGTH, 11, memory address width.
- DATA_LENGTH, 16, memory word width.
- MAX_WAIT, 4, lost arbitrations before the interface is force-granted (>=1).

Ports:
- clk  in  1  system clock; memory operates on negedge, this block on posedge.
- reset  in  1  synchronous, active-high reset.
- bip_req  in  1  BIP access request; held until bip_ack.
- bip_we  in  1  1=write, 0=read; stable while bip_req.
- bip_addr  in  ADDR_LENGTH  BIP address.
- bip_wdata  in  DATA_LENGTH  BIP write data.
- bip_ack  out  1  one-cycle completion pulse.
- bip_rdata  out  DATA_LENGTH  read word; valid when bip_ack and held until next BIP read ack.
- if_req, if_we, if_addr, if_wdata, if_ack, if_rdata: same as the bip_* ports, for the interface requester.
- if_priority  in  1  debug halt; interface wins every arbitration while high.
- mem_wrrd  out  2  to memory WrRdBip: 2'b10 write, 2'b01 read, 2'b00 idle.
- mem_addr  out  ADDR_LENGTH  to addr_from_bip.
- mem_wdata  out  DATA_LENGTH  to data_from_bip.
- mem_rdata  in  DATA_LENGTH  from memory outData.
- busy  out  1  high in ACCESS and RESPOND.
- owner  out  1  0=BIP, 1=interface; valid while busy.

Behaviour:
- Reset values: state IDLE; mem_wrrd=00; mem_addr=0; mem_wdata=0; both acks 0; both rdata 0; busy 0; owner 0; wait counter 0. Reset mid-transaction abandons it: no ack is issued and mem_wrrd returns to 00 on the next edge.
- FSM: IDLE -> ACCESS -> RESPOND -> IDLE. All outputs are registered.
- IDLE, at a posedge with at least one req high:
  - Pick the winner.
  - Register mem_wrrd = we ? 10 : 01, plus mem_addr and mem_wdata from the winner.
  - Set owner and go to ACCESS.
  - With no req, stay in IDLE with mem_wrrd=00.
- ACCESS (exactly one cycle): the command is held and the memory acts on the intervening negedge. At the next posedge:
  - capture mem_rdata into the winner's rdata (reads only; writes leave rdata unchanged);
  - assert the winner's ack;
  - set mem_wrrd=00 and go to RESPOND.
- RESPOND (one cycle): ack is high. Next posedge: ack drops, go to IDLE.
- Requester protocol: the requester must drop req during the ack cycle. A req still high when IDLE next evaluates is a new transaction.
- Latency and throughput:
  - req first sampled at edge N -> ack high between edges N+1 and N+2.
  - One access every 3 cycles maximum.
- Arbitration priority, in order:
  1. if_priority=1 -> interface.
  2. Wait counter == MAX_WAIT and if_req -> interface; counter clears.
  3. Otherwise BIP wins when bip_req, else interface.
- Wait counter:
  - Increments (saturating at MAX_WAIT) on each IDLE arbitration the interface loses while if_req is high.
  - Clears whenever the interface is granted.
  - Width is clog2(MAX_WAIT+1).
- Simultaneous requests: exactly one grant; the loser's req stays pending and is served at the next IDLE evaluation.
- Requester inputs other than req are ignored outside IDLE. Changes to we/addr/wdata mid-transaction have no effect.
- Address wrap: none. Addresses pass through unmodified.

Decomposition:
- Shared package holds:
  - WrRd encodings: WRRD_IDLE=2'b00, WRRD_READ=2'b01, WRRD_WRITE=2'b10 (also used by data_memory).
  - FSM state encodings.
  - Owner encodings: OWNER_BIP=0, OWNER_IF=1.
- One sub-module is natural: arb_priority_sel, a combinational winner select containing the wait counter register.

Test Plan:
- Memory preloaded 1,2,3,4 at 0..3. bip_req read addr 2 -> mem_wrrd=01 one cycle, bip_ack two edges later, bip_rdata=3, if_ack stays 0.
- if write addr 1 data 16'h00AA, then if read addr 1 -> if_rdata=16'h00AA. mem_wrrd sequence 10,00,00,01.
- bip_req and if_req rise on the same edge, reads of addr 0 and 3 -> BIP acked first with 1, interface acked 3 cycles later with 4; owner 0 then 1.
- MAX_WAIT=4, bip_req continuously re-asserted, if_req held -> interface granted on its 5th arbitration, counter returns to 0.
- if_priority=1 with both requesting -> interface wins every arbitration; BIP is served only after if_priority drops.
- reset asserted during ACCESS of a BIP write -> next edge: IDLE, mem_wrrd=00, no bip_ack, all outputs at reset values.

Source files
------------

// File: rtl/data_memory_arbiter_pkg.sv
// Shared encodings for the data memory arbiter and the data memory itself.
// Holds the WrRd command codes, the arbiter FSM states and the owner codes.
package data_memory_arbiter_pkg;

    localparam logic [1:0] WRRD_IDLE  = 2'b00;
    localparam logic [1:0] WRRD_READ  = 2'b01;
    localparam logic [1:0] WRRD_WRITE = 2'b10;

    localparam logic OWNER_BIP = 1'b0;
    localparam logic OWNER_IF  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b01,
        ST_RESPOND = 2'b10
    } arb_state_t;

    function automatic logic [1:0] wrrd_cmd(input logic we);
        return we ? WRRD_WRITE : WRRD_READ;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_arb_priority_sel.sv
// Winner selection between the BIP core and the debug interface.
// Holds the starvation counter that force-grants the interface after MAX_WAIT losses.
module arb_priority_sel
    import data_memory_arbiter_pkg::*;
#(
    parameter int MAX_WAIT   = 4,
    parameter int WAIT_WIDTH = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic arbitrate,
    input  logic bip_req,
    input  logic if_req,
    input  logic if_priority,
    output logic grant_valid,
    output logic grant_owner
);

    logic [WAIT_WIDTH-1:0] wait_count;

    // A debug halt holds the BIP off entirely; only the interface can be granted.
    always_comb begin
        grant_valid = 1'b0;
        grant_owner = OWNER_BIP;
        if (if_priority) begin
            grant_valid = if_req;
            grant_owner = OWNER_IF;
        end else if (if_req && (wait_count == WAIT_WIDTH'(MAX_WAIT))) begin
            grant_valid = 1'b1;
            grant_owner = OWNER_IF;
        end else if (bip_req) begin
            grant_valid = 1'b1;
            grant_owner = OWNER_BIP;
        end else if (if_req) begin
            grant_valid = 1'b1;
            grant_owner = OWNER_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_count <= '0;
        end else if (arbitrate && grant_valid) begin
            if (grant_owner == OWNER_IF) begin
                wait_count <= '0;
            end else if (if_req && (wait_count != WAIT_WIDTH'(MAX_WAIT))) begin
                wait_count <= wait_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single data memory port between the BIP core and the debug/UART interface.
// Each access runs IDLE -> ACCESS -> RESPOND; every output is registered.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_LENGTH = 11,
    parameter int DATA_LENGTH = 16,
    parameter int MAX_WAIT    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bip_req,
    input  logic                   bip_we,
    input  logic [ADDR_LENGTH-1:0] bip_addr,
    input  logic [DATA_LENGTH-1:0] bip_wdata,
    output logic                   bip_ack,
    output logic [DATA_LENGTH-1:0] bip_rdata,
    input  logic                   if_req,
    input  logic                   if_we,
    input  logic [ADDR_LENGTH-1:0] if_addr,
    input  logic [DATA_LENGTH-1:0] if_wdata,
    output logic                   if_ack,
    output logic [DATA_LENGTH-1:0] if_rdata,
    input  logic                   if_priority,
    output logic [1:0]             mem_wrrd,
    output logic [ADDR_LENGTH-1:0] mem_addr,
    output logic [DATA_LENGTH-1:0] mem_wdata,
    input  logic [DATA_LENGTH-1:0] mem_rdata,
    output logic                   busy,
    output logic                   owner
);

    arb_state_t state, state_next;

    logic                   grant_valid;
    logic                   grant_owner;
    logic [1:0]             wrrd_next;
    logic [ADDR_LENGTH-1:0] addr_next;
    logic [DATA_LENGTH-1:0] wdata_next;
    logic                   bip_ack_next;
    logic                   if_ack_next;
    logic [DATA_LENGTH-1:0] bip_rdata_next;
    logic [DATA_LENGTH-1:0] if_rdata_next;
    logic                   owner_next;
    logic                   busy_next;

    arb_priority_sel #(
        .MAX_WAIT (MAX_WAIT)
    ) u_sel (
        .clk         (clk),
        .reset       (reset),
        .arbitrate   (state == ST_IDLE),
        .bip_req     (bip_req),
        .if_req      (if_req),
        .if_priority (if_priority),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // The memory registers its read word on the negedge inside ACCESS, so it is
    // already stable when ACCESS ends; mem_wrrd tells us whether it was a read.
    always_comb begin
        state_next     = state;
        wrrd_next      = WRRD_IDLE;
        addr_next      = mem_addr;
        wdata_next     = mem_wdata;
        bip_ack_next   = 1'b0;
        if_ack_next    = 1'b0;
        bip_rdata_next = bip_rdata;
        if_rdata_next  = if_rdata;
        owner_next     = owner;

        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next = ST_ACCESS;
                    owner_next = grant_owner;
                    if (grant_owner == OWNER_IF) begin
                        wrrd_next  = wrrd_cmd(if_we);
                        addr_next  = if_addr;
                        wdata_next = if_wdata;
                    end else begin
                        wrrd_next  = wrrd_cmd(bip_we);
                        addr_next  = bip_addr;
                        wdata_next = bip_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                state_next = ST_RESPOND;
                if (owner == OWNER_IF) begin
                    if_ack_next = 1'b1;
                    if (mem_wrrd == WRRD_READ) if_rdata_next = mem_rdata;
                end else begin
                    bip_ack_next = 1'b1;
                    if (mem_wrrd == WRRD_READ) bip_rdata_next = mem_rdata;
                end
            end
            ST_RESPOND: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mem_wrrd  <= WRRD_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            bip_ack   <= 1'b0;
            if_ack    <= 1'b0;
            bip_rdata <= '0;
            if_rdata  <= '0;
            owner     <= OWNER_BIP;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            mem_wrrd  <= wrrd_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            bip_ack   <= bip_ack_next;
            if_ack    <= if_ack_next;
            bip_rdata <= bip_rdata_next;
            if_rdata  <= if_rdata_next;
            owner     <= owner_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a negedge memory model behind it.
// Memory holds 1,2,3,4 at 0..3 and 16'h1000+addr elsewhere.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        bip_req, bip_we, if_req, if_we, if_priority;
    logic [10:0] bip_addr, if_addr, mem_addr;
    logic [15:0] bip_wdata, if_wdata, mem_wdata, mem_rdata;
    logic [15:0] bip_rdata, if_rdata;
    logic        bip_ack, if_ack, busy, owner;
    logic [1:0]  mem_wrrd;
    logic [15:0] mem [0:2047];

    int checks = 0;
    int errors = 0;

    data_memory_arbiter #(
        .ADDR_LENGTH (11),
        .DATA_LENGTH (16),
        .MAX_WAIT    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bip_req     (bip_req),
        .bip_we      (bip_we),
        .bip_addr    (bip_addr),
        .bip_wdata   (bip_wdata),
        .bip_ack     (bip_ack),
        .bip_rdata   (bip_rdata),
        .if_req      (if_req),
        .if_we       (if_we),
        .if_addr     (if_addr),
        .if_wdata    (if_wdata),
        .if_ack      (if_ack),
        .if_rdata    (if_rdata),
        .if_priority (if_priority),
        .mem_wrrd    (mem_wrrd),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    // Data memory stand-in: loads its contents while reset is high, acts on negedge.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2048; i++)
                mem[i] <= (i < 4) ? 16'(i + 1) : 16'(16'h1000 + i);
            mem_rdata <= '0;
        end else if (mem_wrrd == 2'b10) begin
            mem[mem_addr] <= mem_wdata;
        end else if (mem_wrrd == 2'b01) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic is_if, input logic req, input logic we,
                                 input logic [10:0] addr, input logic [15:0] wdata);
        if (is_if) begin
            if_req = req; if_we = we; if_addr = addr; if_wdata = wdata;
        end else begin
            bip_req = req; bip_we = we; bip_addr = addr; bip_wdata = wdata;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        if_priority = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd0, 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 11'd0, 16'd0);
        tick(); tick();
        checkOutput("rst_wrrd", 32'(mem_wrrd), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_bip_ack", 32'(bip_ack), 32'd0);
        checkOutput("rst_if_ack", 32'(if_ack), 32'd0);
        checkOutput("rst_bip_rdata", 32'(bip_rdata), 32'd0);
        checkOutput("rst_if_rdata", 32'(if_rdata), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd0);
        checkOutput("rst_wait", 32'(dut.u_sel.wait_count), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("idle_wrrd", 32'(mem_wrrd), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // BIP read of address 2
        applyStimulus(1'b0, 1'b1, 1'b0, 11'd2, 16'd0);
        tick();
        checkOutput("t1_wrrd", 32'(mem_wrrd), 32'd1);
        checkOutput("t1_addr", 32'(mem_addr), 32'd2);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_owner", 32'(owner), 32'd0);
        checkOutput("t1_ack_early", 32'(bip_ack), 32'd0);
        tick();
        checkOutput("t1_wrrd_off", 32'(mem_wrrd), 32'd0);
        checkOutput("t1_bip_ack", 32'(bip_ack), 32'd1);
        checkOutput("t1_bip_rdata", 32'(bip_rdata), 32'd3);
        checkOutput("t1_if_ack", 32'(if_ack), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd2, 16'd0);
        tick();
        checkOutput("t1_ack_drop", 32'(bip_ack), 32'd0);
        checkOutput("t1_busy_done", 32'(busy), 32'd0);
        checkOutput("t1_rdata_held", 32'(bip_rdata), 32'd3);

        // Interface write then read-back of address 1
        applyStimulus(1'b1, 1'b1, 1'b1, 11'd1, 16'h00AA);
        tick();
        checkOutput("t2_wrrd_w", 32'(mem_wrrd), 32'd2);
        checkOutput("t2_owner", 32'(owner), 32'd1);
        checkOutput("t2_wdata", 32'(mem_wdata), 32'h00AA);
        tick();
        checkOutput("t2_wrrd_0a", 32'(mem_wrrd), 32'd0);
        checkOutput("t2_if_ack_w", 32'(if_ack), 32'd1);
        checkOutput("t2_bip_ack", 32'(bip_ack), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 11'd1, 16'd0);
        tick();
        checkOutput("t2_wrrd_0b", 32'(mem_wrrd), 32'd0);
        checkOutput("t2_if_ack_drop", 32'(if_ack), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 11'd1, 16'd0);
        tick();
        checkOutput("t2_wrrd_r", 32'(mem_wrrd), 32'd1);
        checkOutput("t2_addr_r", 32'(mem_addr), 32'd1);
        tick();
        checkOutput("t2_if_ack_r", 32'(if_ack), 32'd1);
        checkOutput("t2_if_rdata", 32'(if_rdata), 32'h00AA);
        applyStimulus(1'b1, 1'b0, 1'b0, 11'd1, 16'd0);
        tick();

        // Simultaneous reads: BIP addr 0, interface addr 3
        applyStimulus(1'b0, 1'b1, 1'b0, 11'd0, 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 11'd3, 16'd0);
        tick();
        checkOutput("t3_owner_bip", 32'(owner), 32'd0);
        checkOutput("t3_addr_bip", 32'(mem_addr), 32'd0);
        checkOutput("t3_wait_1", 32'(dut.u_sel.wait_count), 32'd1);
        tick();
        checkOutput("t3_bip_ack", 32'(bip_ack), 32'd1);
        checkOutput("t3_bip_rdata", 32'(bip_rdata), 32'd1);
        checkOutput("t3_if_ack_0", 32'(if_ack), 32'd0);
        checkOutput("t3_if_rdata_held", 32'(if_rdata), 32'h00AA);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd0, 16'd0);
        tick();
        checkOutput("t3_idle_gap", 32'(busy), 32'd0);
        tick();
        checkOutput("t3_owner_if", 32'(owner), 32'd1);
        checkOutput("t3_addr_if", 32'(mem_addr), 32'd3);
        checkOutput("t3_wait_0", 32'(dut.u_sel.wait_count), 32'd0);
        tick();
        checkOutput("t3_if_ack", 32'(if_ack), 32'd1);
        checkOutput("t3_if_rdata", 32'(if_rdata), 32'd4);
        checkOutput("t3_bip_ack_0", 32'(bip_ack), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 11'd3, 16'd0);
        tick();

        // Starvation: interface held on addr 20, BIP keeps asking for 10..14
        applyStimulus(1'b1, 1'b1, 1'b0, 11'd20, 16'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 11'(10 + i), 16'd0);
            tick();
            checkOutput("t4_owner", 32'(owner), (i == 4) ? 32'd1 : 32'd0);
            checkOutput("t4_wait", 32'(dut.u_sel.wait_count), (i == 4) ? 32'd0 : 32'(i + 1));
            tick();
            if (i < 4) begin
                checkOutput("t4_bip_ack", 32'(bip_ack), 32'd1);
                checkOutput("t4_bip_rdata", 32'(bip_rdata), 32'(16'h100A + i));
                checkOutput("t4_if_ack_0", 32'(if_ack), 32'd0);
                applyStimulus(1'b0, 1'b0, 1'b0, 11'(10 + i), 16'd0);
            end else begin
                checkOutput("t4_if_ack", 32'(if_ack), 32'd1);
                checkOutput("t4_if_rdata", 32'(if_rdata), 32'h1014);
                applyStimulus(1'b1, 1'b0, 1'b0, 11'd20, 16'd0);
            end
            tick();
        end
        tick();
        checkOutput("t4_bip_after", 32'(owner), 32'd0);
        tick();
        checkOutput("t4_bip_rdata_after", 32'(bip_rdata), 32'h100E);
        checkOutput("t4_wait_stay", 32'(dut.u_sel.wait_count), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd14, 16'd0);
        tick();

        // Debug halt: interface wins both arbitrations while if_priority is high
        if_priority = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 11'd3, 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 11'd2, 16'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("t5_owner_if", 32'(owner), 32'd1);
            tick();
            checkOutput("t5_if_ack", 32'(if_ack), 32'd1);
            checkOutput("t5_bip_ack_0", 32'(bip_ack), 32'd0);
            checkOutput("t5_if_rdata", 32'(if_rdata), 32'd3);
            applyStimulus(1'b1, 1'b0, 1'b0, 11'd2, 16'd0);
            tick();
            if (k == 0) applyStimulus(1'b1, 1'b1, 1'b0, 11'd2, 16'd0);
        end
        if_priority = 1'b0;
        tick();
        checkOutput("t5_owner_bip", 32'(owner), 32'd0);
        tick();
        checkOutput("t5_bip_ack", 32'(bip_ack), 32'd1);
        checkOutput("t5_bip_rdata", 32'(bip_rdata), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd3, 16'd0);
        tick();

        // Reset during ACCESS of a BIP write abandons the transaction
        applyStimulus(1'b0, 1'b1, 1'b1, 11'd5, 16'h1234);
        tick();
        checkOutput("t6_wrrd_w", 32'(mem_wrrd), 32'd2);
        checkOutput("t6_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("t6_wrrd", 32'(mem_wrrd), 32'd0);
        checkOutput("t6_bip_ack", 32'(bip_ack), 32'd0);
        checkOutput("t6_busy_0", 32'(busy), 32'd0);
        checkOutput("t6_owner", 32'(owner), 32'd0);
        checkOutput("t6_addr", 32'(mem_addr), 32'd0);
        checkOutput("t6_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("t6_bip_rdata", 32'(bip_rdata), 32'd0);
        checkOutput("t6_if_rdata", 32'(if_rdata), 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd5, 16'd0);
        tick();
        checkOutput("t6_no_late_ack", 32'(bip_ack), 32'd0);
        checkOutput("t6_idle_wrrd", 32'(mem_wrrd), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
